// File: rtl/gf_pkg.sv
// rtl/gf_pkg.sv - shared constants and state encoding for the GF(p) arithmetic unit
package gf_pkg;
    localparam int GF_WIDTH = 32;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FINISH
    } gf_state_t;
endpackage

// File: rtl/gf_mod_addsub.sv
// rtl/gf_mod_addsub.sv - combinational modular add/sub with a carry bit so a+b never overflows
module gf_mod_addsub
    import gf_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    input  logic             sub,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] res;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        if (sub) begin
            res = (a < b) ? diff + {1'b0, p} : diff;
        end else begin
            res = (sum >= {1'b0, p}) ? sum - {1'b0, p} : sum;
        end
        y = res[WIDTH-1:0];
    end
endmodule

// File: rtl/gf_arith_unit.sv
// rtl/gf_arith_unit.sv - GF(p) add/sub/mult/div unit driven by the ECC control FSM
module gf_arith_unit
    import gf_pkg::*;
#(
    parameter int WIDTH = GF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] prime,
    input  logic [1:0]       operation_select,
    input  logic             done_from_control,
    output logic [WIDTH-1:0] result,
    output logic             done_to_control,
    output logic             done_add,
    output logic             done_sub,
    output logic             done_mult,
    output logic             done_div
);
    localparam int CW = $clog2(WIDTH);

    gf_state_t        state;
    logic [WIDTH-1:0] a_q, b_q, p_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] u, v, x1, x2;

    logic [WIDTH-1:0] s0_a, s0_b, y0, y1;
    logic             s0_sub;
    logic [WIDTH-1:0] ud, vd;

    // (x/2) mod p for odd p: odd x is lifted by p first, needing one extra bit
    function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] m);
        logic [WIDTH:0] t;
        t = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return t[WIDTH:1];
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] t;
        t = {1'b0, x} - {1'b0, y};
        if (x < y) t = t + {1'b0, m};
        return t[WIDTH-1:0];
    endfunction

    // Instance 0 doubles the accumulator during MULT and serves add/sub otherwise
    always_comb begin
        s0_a   = a_q;
        s0_b   = b_q;
        s0_sub = (op_q == OP_SUB);
        if (state == ST_MULT) begin
            s0_a   = acc;
            s0_b   = acc;
            s0_sub = 1'b0;
        end
    end

    gf_mod_addsub #(.WIDTH(WIDTH)) u_addsub0 (
        .a(s0_a), .b(s0_b), .p(p_q), .sub(s0_sub), .y(y0)
    );

    gf_mod_addsub #(.WIDTH(WIDTH)) u_addsub1 (
        .a(y0), .b(a_q), .p(p_q), .sub(1'b0), .y(y1)
    );

    assign ud = u - v;
    assign vd = v - u;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= ST_IDLE;
            result          <= '0;
            done_to_control <= 1'b0;
            done_add        <= 1'b0;
            done_sub        <= 1'b0;
            done_mult       <= 1'b0;
            done_div        <= 1'b0;
            a_q             <= '0;
            b_q             <= '0;
            p_q             <= '0;
            op_q            <= OP_ADD;
            acc             <= '0;
            cnt             <= '0;
            u               <= '0;
            v               <= '0;
            x1              <= '0;
            x2              <= '0;
        end else begin
            done_to_control <= 1'b0;
            done_add        <= 1'b0;
            done_sub        <= 1'b0;
            done_mult       <= 1'b0;
            done_div        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (done_from_control) begin
                        a_q  <= in_0;
                        b_q  <= in_1;
                        p_q  <= prime;
                        op_q <= operation_select;
                        acc  <= '0;
                        cnt  <= CW'(WIDTH - 1);
                        u    <= in_1;
                        v    <= prime;
                        x1   <= in_0;
                        x2   <= '0;
                        case (operation_select)
                            OP_MULT: state <= ST_MULT;
                            OP_DIV:  state <= ST_DIV;
                            default: state <= ST_FINISH;
                        endcase
                    end
                end
                ST_MULT: begin
                    acc <= b_q[cnt] ? y1 : y0;
                    if (cnt == '0) state <= ST_FINISH;
                    else cnt <= cnt - 1'b1;
                end
                ST_DIV: begin
                    // u and v are both odd at a subtraction, so the difference halves exactly
                    if (u == '0 || u == WIDTH'(1) || v == WIDTH'(1)) begin
                        state <= ST_FINISH;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= half_mod(x1, p_q);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= half_mod(x2, p_q);
                    end else if (u >= v) begin
                        u  <= ud >> 1;
                        x1 <= half_mod(sub_mod(x1, x2, p_q), p_q);
                    end else begin
                        v  <= vd >> 1;
                        x2 <= half_mod(sub_mod(x2, x1, p_q), p_q);
                    end
                end
                ST_FINISH: begin
                    done_to_control <= 1'b1;
                    case (op_q)
                        OP_ADD: begin
                            result   <= y0;
                            done_add <= 1'b1;
                        end
                        OP_SUB: begin
                            result   <= y0;
                            done_sub <= 1'b1;
                        end
                        OP_MULT: begin
                            result    <= acc;
                            done_mult <= 1'b1;
                        end
                        default: begin
                            result   <= (u == WIDTH'(1)) ? x1 :
                                        (v == WIDTH'(1)) ? x2 : '0;
                            done_div <= 1'b1;
                        end
                    endcase
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gf_arith_unit.sv
// tb/tb_gf_arith_unit.sv - directed self-checking bench for gf_arith_unit
module tb_gf_arith_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_0, in_1, prime;
    logic [1:0]  operation_select;
    logic        done_from_control;
    logic [31:0] result;
    logic        done_to_control, done_add, done_sub, done_mult, done_div;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] P23 = 32'd23;
    localparam logic [31:0] PBIG = 32'hFFFFFFFB;

    gf_arith_unit #(.WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst), .in_0(in_0), .in_1(in_1), .prime(prime),
        .operation_select(operation_select), .done_from_control(done_from_control),
        .result(result), .done_to_control(done_to_control), .done_add(done_add),
        .done_sub(done_sub), .done_mult(done_mult), .done_div(done_div)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] dmask();
        return {done_to_control, done_add, done_sub, done_mult, done_div};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] p,
                          output int lat, output logic [31:0] res, output logic [4:0] m);
        @(negedge clk);
        in_0 = a; in_1 = b; prime = p; operation_select = op;
        done_from_control = 1'b1;
        @(negedge clk);
        done_from_control = 1'b0;
        lat = 0;
        while (!done_to_control && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        m = dmask();
        @(negedge clk);
        chk({tag, "_pulse_end"}, {27'b0, dmask()}, 32'd0);
    endtask

    int          lat;
    logic [31:0] res;
    logic [4:0]  m;
    int          pulses;

    initial begin
        rst = 1'b1;
        in_0 = '0; in_1 = '0; prime = P23; operation_select = 2'b00;
        done_from_control = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_result", result, 32'd0);
        chk("reset_done", {27'b0, dmask()}, 32'd0);

        run_op("add", 2'b00, 32'd20, 32'd5, P23, lat, res, m);
        chk("add_res", res, 32'h02);
        chk("add_lat", lat, 32'd1);
        chk("add_mask", {27'b0, m}, 32'b11000);

        run_op("sub_wrap", 2'b01, 32'd3, 32'd7, P23, lat, res, m);
        chk("sub_wrap_res", res, 32'h13);
        chk("sub_wrap_mask", {27'b0, m}, 32'b10100);
        run_op("sub_zero", 2'b01, 32'd7, 32'd7, P23, lat, res, m);
        chk("sub_zero_res", res, 32'h00);

        run_op("mult", 2'b10, 32'd7, 32'd9, P23, lat, res, m);
        chk("mult_res", res, 32'h11);
        chk("mult_lat", lat, 32'd33);
        chk("mult_mask", {27'b0, m}, 32'b10010);
        run_op("mult_big", 2'b10, PBIG - 1, PBIG - 1, PBIG, lat, res, m);
        chk("mult_big_res", res, 32'h00000001);
        chk("mult_big_lat", lat, 32'd33);

        run_op("div", 2'b11, 32'd6, 32'd4, P23, lat, res, m);
        chk("div_res", res, 32'h0D);
        chk("div_lat_le66", 32'(lat <= 66), 32'd1);
        chk("div_mask", {27'b0, m}, 32'b10001);
        run_op("div_half", 2'b11, 32'd1, 32'd2, P23, lat, res, m);
        chk("div_half_res", res, 32'h0C);
        run_op("div_zero", 2'b11, 32'd5, 32'd0, P23, lat, res, m);
        chk("div_zero_res", res, 32'h00);
        chk("div_zero_lat", lat, 32'd2);
        chk("div_zero_mask", {27'b0, m}, 32'b10001);

        run_op("add_big", 2'b00, 32'hFFFFFFFA, 32'hFFFFFFFA, PBIG, lat, res, m);
        chk("add_big_res", res, 32'hFFFFFFF9);
        run_op("sub_big", 2'b01, 32'd0, 32'd1, PBIG, lat, res, m);
        chk("sub_big_res", res, 32'hFFFFFFFA);

        // A second start while the multiplier is busy must be dropped
        @(negedge clk);
        in_0 = 32'd7; in_1 = 32'd9; prime = P23; operation_select = 2'b10;
        done_from_control = 1'b1;
        pulses = 0;
        res = '0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            done_from_control = (i == 5);
            if (i == 5) begin
                in_0 = 32'd1; in_1 = 32'd1; operation_select = 2'b00;
            end
            if (done_to_control) begin
                pulses++;
                res = result;
            end
        end
        chk("busy_pulses", pulses, 32'd1);
        chk("busy_res", res, 32'h11);

        // Reset in the middle of a long division aborts it silently
        @(negedge clk);
        in_0 = 32'd5; in_1 = 32'h12345677; prime = PBIG; operation_select = 2'b11;
        done_from_control = 1'b1;
        @(negedge clk);
        done_from_control = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done_to_control) pulses++;
        end
        chk("rst_div_pulses", pulses, 32'd0);
        chk("rst_div_result", result, 32'd0);
        run_op("post_rst_add", 2'b00, 32'd20, 32'd5, P23, lat, res, m);
        chk("post_rst_add_res", res, 32'h02);
        chk("post_rst_add_mask", {27'b0, m}, 32'b11000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
